// File: rtl/tdm_demux_led_pkg.sv
// Shared TDM definitions: frame size default and FSM state encoding.
// The matching TDM transmitter imports the same package.
package tdm_demux_led_pkg;

  localparam int N_CH_DEF = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } tdm_state_t;

endpackage

// File: rtl/tdm_demux_led_slot_counter.sv
// Slot counter for the TDM receiver.
// Cleared, reloaded to 1 or advanced; flags the final slot.
module tdm_slot_counter #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load1,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  // slot index; only the receiver FSM decides when it moves
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      unique case (1'b1)
        clear:   cnt <= '0;
        load1:   cnt <= CNT_W'(1);
        inc:     cnt <= cnt + 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign last = (cnt == CNT_W'(N_CH - 1));

endmodule

// File: rtl/tdm_demux_led.sv
// TDM 1:N receiver driving an LED bank.
// Slots gather in a shadow register; LEDs update once per full frame.
module tdm_demux_led
  import tdm_demux_led_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int CNT_W = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tick,
  input  logic            sync,
  input  logic            din,
  output logic [N_CH-1:0] led,
  output logic            frame_valid,
  output logic            sync_err
);

  tdm_state_t       state;
  tdm_state_t       nxt;
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic             clr;
  logic             ld1;
  logic             inc;
  logic             wr;
  logic [CNT_W-1:0] widx;
  logic             ld_led;
  logic             fv_d;
  logic             err_d;
  logic [N_CH-1:0]  shadow;

  tdm_slot_counter #(
    .N_CH  (N_CH),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (clr),
    .load1 (ld1),
    .inc   (inc),
    .cnt   (cnt),
    .last  (last)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= nxt;
  end

  // next state and per-slot control; nothing moves without tick
  always_comb begin
    nxt    = state;
    clr    = 1'b0;
    ld1    = 1'b0;
    inc    = 1'b0;
    wr     = 1'b0;
    widx   = cnt;
    ld_led = 1'b0;
    fv_d   = 1'b0;
    err_d  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (tick && sync) begin
          wr   = 1'b1;
          widx = '0;
          ld1  = 1'b1;
          nxt  = ST_RECV;
        end
      end
      ST_RECV: begin
        unique case (1'b1)
          (tick && sync): begin
            // early sync restarts at slot 0
            wr    = 1'b1;
            widx  = '0;
            ld1   = 1'b1;
            err_d = !sync_err;
          end
          (tick && !sync): begin
            wr = 1'b1;
            if (last) begin
              ld_led = 1'b1;
              fv_d   = 1'b1;
              clr    = 1'b1;
              nxt    = ST_IDLE;
            end else begin
              inc = 1'b1;
            end
          end
          default: ;
        endcase
      end
      default: nxt = ST_IDLE;
    endcase
  end

  // shadow capture, atomic LED load and registered status pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow      <= '0;
      led         <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      if (wr)     shadow[widx] <= din;
      if (ld_led) led <= {din, shadow[N_CH-2:0]};
      frame_valid <= fv_d;
      sync_err    <= err_d;
    end
  end

endmodule

// File: tb/tb_tdm_demux_led.sv
// Directed bench for tdm_demux_led (N_CH=4).
// One task per scenario, inline checks, one summary line.
module tb_tdm_demux_led;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       sync = 1'b0;
  logic       din = 1'b0;
  logic [3:0] led;
  logic       frame_valid;
  logic       sync_err;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int fv_n = 0;
  int fv_run = 0;
  int fv_long = 0;
  int fv_prev = 0;
  int fv_gap = 0;
  int err_n = 0;
  int err_run = 0;
  int err_long = 0;

  tdm_demux_led #(
    .N_CH  (4),
    .CNT_W (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .sync        (sync),
    .din         (din),
    .led         (led),
    .frame_valid (frame_valid),
    .sync_err    (sync_err)
  );

  always #5 clk = ~clk;

  // pulse monitor: counts, widths and spacing of status pulses
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (frame_valid === 1'b1) begin
      if (fv_run == 0) begin
        fv_n    = fv_n + 1;
        fv_gap  = cyc - fv_prev;
        fv_prev = cyc;
      end
      fv_run = fv_run + 1;
      if (fv_run == 2) fv_long = fv_long + 1;
    end else begin
      fv_run = 0;
    end
    if (sync_err === 1'b1) begin
      if (err_run == 0) err_n = err_n + 1;
      err_run = err_run + 1;
      if (err_run == 2) err_long = err_long + 1;
    end else begin
      err_run = 0;
    end
  end

  task automatic slot(input logic s, input logic d);
    @(negedge clk);
    tick = 1'b1;
    sync = s;
    din  = d;
    @(negedge clk);
    tick = 1'b0;
    sync = 1'b0;
    din  = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (led !== 4'b0000) begin
      errors++;
      $display("FAIL reset_led got %b want 0000", led);
    end
    checks++;
    if (frame_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_fv got %b want 0", frame_valid);
    end
    checks++;
    if (sync_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_err got %b want 0", sync_err);
    end
  endtask

  task automatic test_normal();
    int f0, l0;
    f0 = fv_n;
    l0 = fv_long;
    slot(1'b1, 1'b1);
    slot(1'b0, 1'b0);
    slot(1'b0, 1'b1);
    slot(1'b0, 1'b1);
    checks++;
    if (led !== 4'b1101) begin
      errors++;
      $display("FAIL normal_led got %b want 1101", led);
    end
    checks++;
    if (fv_n - f0 != 1) begin
      errors++;
      $display("FAIL normal_fv_count got %0d want 1", fv_n - f0);
    end
    checks++;
    if (fv_long != l0) begin
      errors++;
      $display("FAIL normal_fv_width got long %0d want 0",
               fv_long - l0);
    end
  endtask

  task automatic test_async_reset();
    slot(1'b1, 1'b0);
    slot(1'b0, 1'b1);
    slot(1'b0, 1'b1);
    @(negedge clk);
    tick = 1'b1;
    din  = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (led !== 4'b0110 || frame_valid !== 1'b1) begin
      errors++;
      $display("FAIL arst_pre got led %b fv %b want 0110 1",
               led, frame_valid);
    end
    #1;
    tick = 1'b0;
    din  = 1'b0;
    rst  = 1'b1;
    #1;
    checks++;
    if (led !== 4'b0000) begin
      errors++;
      $display("FAIL arst_led got %b want 0000", led);
    end
    checks++;
    if (frame_valid !== 1'b0 || sync_err !== 1'b0) begin
      errors++;
      $display("FAIL arst_flags got fv %b err %b want 0 0",
               frame_valid, sync_err);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_nosync();
    int f0;
    f0 = fv_n;
    for (int i = 0; i < 8; i++) slot(1'b0, 1'b1);
    // sync without tick must be ignored as well
    @(negedge clk);
    sync = 1'b1;
    din  = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    din  = 1'b0;
    for (int i = 0; i < 3; i++) slot(1'b0, 1'b1);
    checks++;
    if (led !== 4'b0000) begin
      errors++;
      $display("FAIL nosync_led got %b want 0000", led);
    end
    checks++;
    if (fv_n != f0) begin
      errors++;
      $display("FAIL nosync_fv got %0d want 0", fv_n - f0);
    end
  endtask

  task automatic test_early_sync();
    int f0, e0, el0;
    f0  = fv_n;
    e0  = err_n;
    el0 = err_long;
    slot(1'b1, 1'b1);
    slot(1'b0, 1'b1);
    slot(1'b1, 1'b0);
    checks++;
    if (led !== 4'b0000) begin
      errors++;
      $display("FAIL early_led_hold got %b want 0000", led);
    end
    slot(1'b0, 1'b1);
    slot(1'b0, 1'b0);
    slot(1'b0, 1'b1);
    checks++;
    if (led !== 4'b1010) begin
      errors++;
      $display("FAIL early_led got %b want 1010", led);
    end
    checks++;
    if (err_n - e0 != 1 || err_long != el0) begin
      errors++;
      $display("FAIL early_err got pulses %0d long %0d want 1 0",
               err_n - e0, err_long - el0);
    end
    checks++;
    if (fv_n - f0 != 1) begin
      errors++;
      $display("FAIL early_fv got %0d want 1", fv_n - f0);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] fa, fb;
    int f0, l0;
    fa = 4'b0110;
    fb = 4'b1001;
    f0 = fv_n;
    l0 = fv_long;
    @(negedge clk);
    tick = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sync = (i == 0);
      din  = fa[i];
      @(negedge clk);
    end
    checks++;
    if (led !== fa) begin
      errors++;
      $display("FAIL b2b_led_a got %b want 0110", led);
    end
    for (int i = 0; i < 4; i++) begin
      sync = (i == 0);
      din  = fb[i];
      @(negedge clk);
    end
    tick = 1'b0;
    sync = 1'b0;
    din  = 1'b0;
    checks++;
    if (led !== fb) begin
      errors++;
      $display("FAIL b2b_led_b got %b want 1001", led);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (fv_n - f0 != 2 || fv_long != l0) begin
      errors++;
      $display("FAIL b2b_fv got pulses %0d long %0d want 2 0",
               fv_n - f0, fv_long - l0);
    end
    checks++;
    if (fv_gap != 4) begin
      errors++;
      $display("FAIL b2b_gap got %0d want 4", fv_gap);
    end
  endtask

  task automatic test_reset_mid();
    int f0;
    slot(1'b1, 1'b1);
    slot(1'b0, 1'b1);
    do_reset();
    f0 = fv_n;
    slot(1'b1, 1'b1);
    slot(1'b0, 1'b1);
    slot(1'b0, 1'b0);
    slot(1'b0, 1'b0);
    checks++;
    if (led !== 4'b0011) begin
      errors++;
      $display("FAIL rstmid_led got %b want 0011", led);
    end
    checks++;
    if (fv_n - f0 != 1) begin
      errors++;
      $display("FAIL rstmid_fv got %0d want 1", fv_n - f0);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_async_reset();
    test_nosync();
    test_early_sync();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
